// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register plus bit counter for the UART framer.
// Latency: load/shift/count take effect on the next rising edge; ser_bit_o/ser_done_o are decodes of that state.
// Backpressure: none; the framer FSM sequences load/shift/count.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  shift_en_i,
    input  logic                  cnt_en_i,
    input  logic                  cnt_clr_i,
    input  logic [CNT_WIDTH-1:0]  cnt_last_i,
    output logic                  ser_bit_o,
    output logic                  ser_done_o
);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    // Next-state for shift register and counter; load wins over everything.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = '0;
        end else begin
            if (shift_en_i) begin
                shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            end
            if (cnt_clr_i) begin
                cnt_d = '0;
            end else if (cnt_en_i) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ser_bit_o  = shift_q[0];
    assign ser_done_o = (cnt_q == cnt_last_i);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_WIDTH bits LSB-first, optional parity, stop (two stops with UART_TX_TWO_STOP_EN).
// Latency: TX_OUT shows the start bit and Busy rises on the same edge that accepts DATA_Valid.
// Backpressure: DATA_Valid is ignored while Busy=1; a held DATA_Valid re-arms after one IDLE cycle.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_Valid,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_e            state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 par_en_q, par_en_d;

    logic                 ser_load, ser_shift, ser_cnt_en, ser_cnt_clr;
    logic [CNT_WIDTH-1:0] ser_cnt_last;
    logic                 ser_bit, ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_ser (
        .clk_i      (CLK),
        .rst_n_i    (RST),
        .load_i     (ser_load),
        .data_i     (P_DATA),
        .shift_en_i (ser_shift),
        .cnt_en_i   (ser_cnt_en),
        .cnt_clr_i  (ser_cnt_clr),
        .cnt_last_i (ser_cnt_last),
        .ser_bit_o  (ser_bit),
        .ser_done_o (ser_done)
    );

    // Next state plus the line level for the coming cycle; TX_OUT is
    // registered, so each branch decides what the line shows after the edge.
    always_comb begin
        state_d      = state_q;
        par_en_d     = par_en_q;
        tx_d         = IDLE_LEVEL;
        ser_load     = 1'b0;
        ser_shift    = 1'b0;
        ser_cnt_en   = 1'b0;
        ser_cnt_clr  = 1'b0;
        ser_cnt_last = CNT_WIDTH'(DATA_WIDTH - 1);
        unique case (state_q)
            IDLE: begin
                if (DATA_Valid) begin
                    ser_load = 1'b1;
                    par_en_d = PAR_EN;
                    state_d  = START;
                    tx_d     = START_BIT;
                end
            end
            START: begin
                // Present bit 0 and advance so ser_bit holds the next payload bit.
                state_d   = DATA;
                tx_d      = ser_bit;
                ser_shift = 1'b1;
            end
            DATA: begin
                if (ser_done) begin
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit;
                    end else begin
                        state_d     = STOP;
                        tx_d        = STOP_BIT;
                        ser_cnt_clr = 1'b1;
                    end
                end else begin
                    tx_d       = ser_bit;
                    ser_shift  = 1'b1;
                    ser_cnt_en = 1'b1;
                end
            end
            PARITY: begin
                state_d     = STOP;
                tx_d        = STOP_BIT;
                ser_cnt_clr = 1'b1;
            end
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                // Counter was cleared on entry; second stop cycle is at count 1.
                ser_cnt_last = CNT_WIDTH'(1);
                if (ser_done) begin
                    state_d = IDLE;
                    tx_d    = IDLE_LEVEL;
                end else begin
                    tx_d       = STOP_BIT;
                    ser_cnt_en = 1'b1;
                end
`else
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
`endif
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            tx_q     <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            par_en_q <= par_en_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed scenarios followed by random traffic, scored per line cycle.
// Latency: the reference model predicts {TX_OUT,Busy} for every cycle after each rising edge.
// Backpressure: stimulus waits for Busy=0 before directed frames; random traffic ignores Busy.
module tb_uart_tx_frame;

    localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic         CLK        = 1'b0;
    logic         RST        = 1'b0;
    logic [W-1:0] P_DATA     = '0;
    logic         DATA_Valid = 1'b0;
    logic         PAR_EN     = 1'b0;
    logic         par_bit    = 1'b0;
    logic         TX_OUT;
    logic         Busy;

    int vectors     = 0;
    int miscompares = 0;

    // Expected {tx, busy} per line cycle, produced by the model, consumed by the monitor.
    logic [1:0] exp_q[$];
    // Model's pending line cycles of the frame currently on the wire.
    logic [1:0] frame_q[$];
    logic       model_busy = 1'b0;

    uart_tx_frame #(
        .DATA_WIDTH (W),
        .CNT_WIDTH  (3)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_Valid (DATA_Valid),
        .PAR_EN     (PAR_EN),
        .par_bit    (par_bit),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    // Reference model: a frame is a list of line levels; a new one starts only
    // when the previous line cycle was idle and DATA_Valid is high.
    always @(posedge CLK) begin
        logic [1:0] cur;
        if (!RST) begin
            frame_q.delete();
            cur = 2'b10;
        end else if (frame_q.size() > 0) begin
            cur = frame_q.pop_front();
        end else if (!model_busy && DATA_Valid) begin
            frame_q.push_back(2'b01);
            for (int i = 0; i < W; i++) frame_q.push_back({P_DATA[i], 1'b1});
            if (PAR_EN) frame_q.push_back({^P_DATA, 1'b1});
            for (int i = 0; i < NSTOP; i++) frame_q.push_back(2'b11);
            cur = frame_q.pop_front();
            // Stand-in for the upstream even-parity calculator.
            par_bit = ^P_DATA;
        end else begin
            cur = 2'b10;
        end
        model_busy = cur[0];
        exp_q.push_back(cur);
    end

    // Monitor: compare the DUT line against the model every cycle.
    always @(negedge CLK) begin
        logic [1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({TX_OUT, Busy} !== e) begin
                miscompares++;
                $display("FAIL line t=%0t TX_OUT,Busy got %b%b expected %b%b",
                         $time, TX_OUT, Busy, e[1], e[0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle Busy got %b expected 0 within 100 cycles", Busy);
        end
    endtask

    // One-cycle DATA_Valid pulse issued during an IDLE cycle.
    task automatic send(input logic [W-1:0] d, input logic pe);
        wait_idle();
        P_DATA     = d;
        PAR_EN     = pe;
        DATA_Valid = 1'b1;
        tick(1);
        DATA_Valid = 1'b0;
    endtask

    initial begin
        // Reset held for three cycles, then quiet line.
        RST = 1'b0;
        tick(3);
        RST = 1'b1;
        tick(4);

        // Even-parity 0xA5 frame, then no-parity 0x0F frame.
        send(8'hA5, 1'b1);
        wait_idle();
        tick(2);
        send(8'h0F, 1'b0);
        wait_idle();
        tick(2);

        // DATA_Valid mid-frame must be dropped.
        send(8'hA5, 1'b1);
        tick(4);
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        DATA_Valid = 1'b1;
        tick(1);
        DATA_Valid = 1'b0;
        wait_idle();
        tick(3);

        // Held DATA_Valid: 0x55 then 0xAA back to back.
        P_DATA     = 8'h55;
        PAR_EN     = 1'b1;
        DATA_Valid = 1'b1;
        tick(1);
        P_DATA = 8'hAA;
        wait_idle();
        tick(1);
        DATA_Valid = 1'b0;
        wait_idle();
        tick(2);

        // Reset while data bit 4 is on the line, then a clean frame.
        send(8'hC3, 1'b1);
        tick(5);
        RST = 1'b0;
        tick(1);
        RST = 1'b1;
        tick(2);
        send(8'h96, 1'b0);
        wait_idle();
        tick(2);

        // Random traffic: pulses, held levels, mid-frame data changes, occasional reset.
        for (int c = 0; c < 600; c++) begin
            DATA_Valid = ($urandom_range(0, 3) == 0);
            P_DATA     = W'($urandom);
            PAR_EN     = 1'($urandom);
            RST        = ($urandom_range(0, 79) != 0);
            tick(1);
        end
        RST        = 1'b1;
        DATA_Valid = 1'b0;
        wait_idle();
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit framer and serializer. It accepts a parallel byte with a DATA_Valid strobe and emits a serial frame on TX_OUT at one bit per CLK; CLK is the baud-rate clock. The frame is start bit, data LSB-first, optional parity bit, then stop bit. It sits directly downstream of the parity calculator and consumes its registered par_bit during the PARITY state.

Parameters:
DATA_WIDTH, 8, payload bits per frame.
CNT_WIDTH, 3, bit-counter width; must be at least clog2(DATA_WIDTH).

Ports:
CLK  in  1  baud clock; all logic on rising edge.
RST  in  1  synchronous, active-low reset, sampled on rising CLK.
P_DATA  in  DATA_WIDTH  parallel payload; sampled only on acceptance.
DATA_Valid  in  1  payload strobe; a one-cycle pulse or held level are both legal.
PAR_EN  in  1  1 = frame carries a parity bit; latched on acceptance.
par_bit  in  1  parity bit from the parity calculator; sampled in the PARITY state only.
TX_OUT  out  1  serial line; idles high.
Busy  out  1  high from the first start-bit cycle through the last stop-bit cycle.

Behaviour:
- Single clock CLK. Reset RST is synchronous and active-low. While RST=0 at a rising edge:
  - state <= IDLE, TX_OUT <= 1, Busy <= 0;
  - shift register and bit counter <= 0.
- Reset asserted mid-frame aborts the frame. TX_OUT=1 and Busy=0 from the next edge; no partial stop bit.
- All outputs are registered; no combinational path from any input to TX_OUT or Busy.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX_OUT=1, Busy=0. If DATA_Valid=1 at edge k: latch P_DATA and PAR_EN, go to START. From edge k: TX_OUT=0, Busy=1 (latency 1 cycle).
  - START: one cycle, then DATA with the counter cleared.
  - DATA: TX_OUT = shift[0]; shift right each cycle; counter increments. Leave after DATA_WIDTH cycles (counter = DATA_WIDTH-1): to PARITY if latched PAR_EN=1, else to STOP.
  - PARITY: one cycle, TX_OUT = par_bit. par_bit has been stable since the edge after acceptance, so no extra alignment is needed.
  - STOP: TX_OUT=1 for one cycle, then IDLE with Busy=0 on the following edge.
- Frame length: 1 + DATA_WIDTH + PAR_EN + 1 cycles (11 or 10 at defaults). The minimum gap between frames is one IDLE cycle.
- DATA_Valid while Busy=1 is ignored; no queueing.
- DATA_Valid held high continuously produces back-to-back frames, each separated by exactly one IDLE cycle and each re-sampling P_DATA.
- Changes to P_DATA or PAR_EN mid-frame have no effect.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts two cycles, using the bit counter. Frame length becomes 1 + DATA_WIDTH + PAR_EN + 2.
- Undefined: exactly one stop bit, as above.
- No port or parameter differences between the two builds.

Decomposition:
- Package uart_tx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP; 3-bit encoding);
  - line-level constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1;
  - default DATA_WIDTH.
- One sub-module is natural: uart_tx_serializer.
  - Contains the load/shift register and bit counter.
  - Inputs: load, shift_en. Outputs: ser_bit, ser_done.
  - The FSM and output mux stay in uart_tx_frame.

Test Plan:
- Reset behaviour: hold RST=0 for 3 cycles, then release. TX_OUT=1 and Busy=0 throughout and after; no activity without DATA_Valid.
- Even-parity frame: P_DATA=0xA5, PAR_EN=1, par_bit=0 (even parity, driven by a Parity_Calc instance), one-cycle DATA_Valid. TX_OUT sequence from the next edge is 0,1,0,1,0,0,1,0,1,0,1. Busy is high for exactly 11 cycles.
- No-parity frame: P_DATA=0x0F, PAR_EN=0. TX_OUT is 0,1,1,1,1,0,0,0,0,1 (10 cycles), then 1 idle.
- Busy protection: DATA_Valid pulsed with P_DATA=0x3C mid-frame of 0xA5. The frame is unaffected and no second frame is emitted.
- Held DATA_Valid: P_DATA=0x55 then 0xAA. Two frames separated by exactly one cycle of TX_OUT=1 and Busy=0; second frame carries 0xAA.
- Mid-frame reset: assert RST=0 in the DATA state at bit 4. TX_OUT=1 and Busy=0 on the next edge. A subsequent DATA_Valid produces a clean full frame.
- With UART_TX_TWO_STOP_EN defined: the 0xA5 frame ends with two 1 stop cycles and Busy is high for 12 cycles.
